// File: rtl/matinv_stream_if.sv
// Streams 16 matrix elements into a packed matrix, pulses start to the inverter, then streams the inverse back out.
// Latency: start rises 1 cycle after element 15 is accepted; out_valid rises 1 cycle after inv_done is sampled in WAIT.
// Backpressure: in_ready is high only in LOAD; in UNLOAD out_data holds while out_ready is low. WAIT aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_data/valid/ready: upstream element stream (element 0 first)
//   mat, start        : packed matrix and one-cycle start pulse to the inverter
//   inv, inv_done     : packed inverse and result strobe from the inverter
//   out_data/valid/ready: downstream inverse element stream (element 0 first)
//   busy, err         : not-in-LOAD indicator, sticky timeout flag
module matinv_stream_if #(
    parameter int DW      = 64,
    parameter int NEL     = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW*NEL-1:0] mat,
    output logic              start,
    input  logic [DW*NEL-1:0] inv,
    input  logic              inv_done,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;          // element index, shared by LOAD and UNLOAD
    logic [TW-1:0] tcnt;         // cycles spent in WAIT
    logic [DW-1:0] mat_q [NEL];
    logic [DW-1:0] obuf  [NEL];
    logic          in_acc;
    logic          out_acc;
    logic          timeout;
    logic          last;

    assign in_acc  = in_ready && in_valid;
    assign out_acc = out_valid && out_ready;
    assign last    = (cnt == 4'(NEL - 1));
    // Last permitted WAIT cycle; inv_done on this cycle still wins.
    assign timeout = (tcnt == TW'(TIMEOUT - 1));

    // Element k lives at the top of the packed bus when k = 0.
    for (genvar k = 0; k < NEL; k++) begin : g_pack
        assign mat[DW*(NEL-k)-1 -: DW] = mat_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        out_data  = '0;
        case (state)
            LOAD: begin
                in_ready = !rst;
                busy     = 1'b0;
                if (in_acc && last) state_nxt = START;
            end
            START: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (inv_done)     state_nxt = UNLOAD;
                else if (timeout) state_nxt = LOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = obuf[cnt];
                if (out_acc && last) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tcnt <= '0;
            err  <= 1'b0;
            for (int k = 0; k < NEL; k++) begin
                mat_q[k] <= '0;
                obuf[k]  <= '0;
            end
        end else begin
            // in_acc and out_acc are never both high, so one counter
            // serves both directions and wraps to 0 on the 16th element.
            if (in_acc) begin
                mat_q[cnt] <= in_data;
                cnt        <= cnt + 4'd1;
            end
            if (out_acc) cnt <= cnt + 4'd1;

            // err is cleared as the FSM heads into START so it is low
            // during the start pulse itself.
            if (state == LOAD && state_nxt == START) err <= 1'b0;

            if (state == START)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 1'b1;

            if (state == WAIT) begin
                if (inv_done) begin
                    for (int k = 0; k < NEL; k++)
                        obuf[k] <= inv[DW*(NEL-k)-1 -: DW];
                end else if (timeout) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matinv_stream_if.sv
module tb_matinv_stream_if;

    localparam int DW  = 64;
    localparam int NEL = 16;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW*NEL-1:0] mat;
    logic              start;
    logic [DW*NEL-1:0] inv = '0;
    logic              inv_done = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    matinv_stream_if #(.DW(DW), .NEL(NEL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mat(mat), .start(start),
        .inv(inv), .inv_done(inv_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [DW*NEL-1:0] act, input logic [DW*NEL-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] m_mat [NEL];
    int            m_loaded = 0;
    bit            m_start = 0;
    bit            m_wait = 0;
    int            m_wcnt = 0;
    bit            m_err = 0;
    logic [DW-1:0] outq [$];
    bit            chk_en = 0;
    int            start_seen = 0;

    initial for (int k = 0; k < NEL; k++) m_mat[k] = '0;

    always @(negedge clk) begin
        logic [DW*NEL-1:0] e_mat;
        bit                e_busy;
        bit                e_rdy;
        if (chk_en) begin
            e_busy = m_start || m_wait || (outq.size() != 0);
            e_rdy  = !rst && !e_busy;
            for (int k = 0; k < NEL; k++) e_mat[DW*(NEL-k)-1 -: DW] = m_mat[k];
            chk("in_ready", in_ready, e_rdy);
            chk("busy", busy, e_busy);
            chk("start", start, m_start);
            chk("err", err, m_err);
            chk("out_valid", out_valid, outq.size() != 0);
            chk("out_data", out_data, (outq.size() != 0) ? outq[0] : 64'd0);
            chk("mat", mat, e_mat);
            chk("ready_valid_excl", in_ready && out_valid, 1'b0);
            if (start) start_seen++;

            // advance the model across the coming edge
            if (rst) begin
                for (int k = 0; k < NEL; k++) m_mat[k] = '0;
                m_loaded = 0; m_start = 0; m_wait = 0; m_wcnt = 0; m_err = 0;
                outq.delete();
            end else if (e_rdy && in_valid) begin
                m_mat[m_loaded] = in_data;
                m_loaded++;
                if (m_loaded == NEL) begin
                    m_loaded = 0;
                    m_start  = 1;
                    m_err    = 0;
                end
            end else if (m_start) begin
                m_start = 0;
                m_wait  = 1;
                m_wcnt  = 0;
            end else if (m_wait) begin
                if (inv_done) begin
                    for (int k = 0; k < NEL; k++) outq.push_back(inv[DW*(NEL-k)-1 -: DW]);
                    m_wait = 0;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        m_err  = 1;
                        m_wait = 0;
                    end
                end
            end else if (outq.size() != 0 && out_ready) begin
                void'(outq.pop_front());
            end
        end
    end

    // ---------------- inverter model ----------------
    int            lat = 20;
    bit            resp_en = 1;
    bit            noise_en = 0;
    logic [DW-1:0] first_elem = 64'h4000_0000_0000_0000;

    initial begin
        int cd;
        cd = 0;
        forever begin
            @(posedge clk);
            #1;
            inv_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    inv_done = 1'b1;
                    for (int k = 1; k < NEL; k++) inv[DW*(NEL-k)-1 -: DW] = {$urandom, $urandom};
                    inv[DW*NEL-1 -: DW] = first_elem;
                end
            end
            if (!inv_done && noise_en && $urandom_range(0, 9) == 0) begin
                inv_done = 1'b1;
                for (int k = 0; k < NEL; k++) inv[DW*(NEL-k)-1 -: DW] = {$urandom, $urandom};
            end
            if (start && resp_en) cd = lat;
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] elems [NEL];

    // Returns in the cycle after element 15 was accepted (the START cycle).
    task automatic load(input bit alt);
        for (int k = 0; k < NEL; k++) begin
            if (alt) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = elems[k];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n, w, s0;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1'b1);
        chk("post_reset_mat", mat, '0);

        // Identity-like matrix, continuous valid, inverter answers after 20 cycles.
        for (int k = 0; k < NEL; k++) elems[k] = '0;
        elems[0]  = 64'h3FF0_0000_0000_0000;
        elems[4]  = 64'h4008_0000_0000_0000;
        elems[15] = 64'h3FF0_0000_0000_0000;
        lat = 20;
        s0  = start_seen;
        load(0);
        @(negedge clk);
        chk("start_after_16", start, 1'b1);
        chk("mat_elem0", mat[1023:960], 64'h3FF0_0000_0000_0000);
        chk("mat_elem4", mat[767:704], 64'h4008_0000_0000_0000);
        chk("mat_elem15", mat[63:0], 64'h3FF0_0000_0000_0000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("unload_latency", n, 21);
        chk("first_out", out_data, 64'h4000_0000_0000_0000);
        w = 0; n = 0;
        while (w < NEL && n < 100) begin
            if (out_valid && out_ready) w++;
            @(negedge clk);
            n++;
        end
        chk("words_cont", w, 16);
        chk("idle_after_unload", busy, 1'b0);
        chk("single_start_cont", start_seen - s0, 1);

        // Alternate-cycle valid, out_ready toggled 1,0,0,1.
        for (int k = 0; k < NEL; k++) elems[k] = {$urandom, $urandom};
        lat = 5;
        s0  = start_seen;
        load(1);
        @(negedge clk);
        chk("mat_alt_elem0", mat[1023:960], elems[0]);
        w = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            out_ready = pat[i % 4];
            @(negedge clk);
            if (out_valid && out_ready) w++;
        end
        out_ready = 1'b1;
        chk("words_stalled", w, 16);
        chk("single_start_alt", start_seen - s0, 1);

        // Inverter never answers: abort after 64 WAIT cycles.
        resp_en = 0;
        load(0);
        @(negedge clk);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 65);
        chk("timeout_in_load", in_ready, 1'b1);
        resp_en = 1;
        lat = 3;
        load(0);
        @(negedge clk);
        chk("err_cleared_at_start", err, 1'b0);
        repeat (40) @(negedge clk);

        // Reset after 7 accepted elements discards them.
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mat_cleared_by_reset", mat, '0);
        for (int k = 0; k < NEL; k++) elems[k] = {$urandom, $urandom};
        load(0);
        @(negedge clk);
        chk("mat_after_reset_e0", mat[1023:960], elems[0]);
        chk("mat_after_reset_e15", mat[63:0], elems[15]);
        repeat (40) @(negedge clk);

        // Randomised traffic with spurious inv_done and occasional resets.
        noise_en = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            lat       = $urandom_range(1, 80);
            first_elem = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        noise_en = 0;
        repeat (200) @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/matinv_stream_if.md
MATINV_STREAM_IF -- requirements
Module: matinv_stream_if

Interface
Parameters:
REQ-001 DW, 64, element width in bits (IEEE-754 double).
REQ-002 NEL, 16, elements per matrix (4x4, row-major).
REQ-003 TIMEOUT, 4096, maximum cycles to wait for inv_done before aborting.

Ports:
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_data  input  DW  upstream matrix element.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 mat  output  DW*NEL  packed matrix to matinv inp.
REQ-010 start  output  1  one-cycle start pulse to matinv.
REQ-011 inv  input  DW*NEL  packed inverse from matinv ainv.
REQ-012 inv_done  input  1  matinv result valid; sampled only in WAIT.
REQ-013 out_data  output  DW  downstream inverse element.
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 busy  output  1  high in any state other than LOAD.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have states LOAD, START, WAIT, UNLOAD; reset state LOAD.
REQ-019 Transfers SHALL occur only on cycles where valid and ready are both high.
REQ-020 LOAD: in_ready SHALL be 1; accepted element k (0..15) SHALL be written to mat[DW*(NEL-k)-1 -: DW], so element 0 occupies mat[1023:960].
REQ-021 Accepting element 15 SHALL move the FSM to START on that edge.
REQ-022 START: start SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT with the timeout counter cleared.
REQ-023 mat SHALL be held stable from the end of LOAD until the first acceptance of the next LOAD.
REQ-024 WAIT: in_ready=0; when inv_done=1, inv SHALL be captured into a 16-entry output buffer and the FSM SHALL enter UNLOAD.
REQ-025 WAIT: if TIMEOUT cycles elapse without inv_done, err SHALL be set and the FSM SHALL return to LOAD with no output words.
REQ-026 inv_done in LOAD, START or UNLOAD SHALL be ignored.
REQ-027 UNLOAD: out_valid SHALL be 1, out_data SHALL be buffer element j (0..15), MSB element first, the same order as REQ-020.
REQ-028 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 The handshake accepting element 15 SHALL return the FSM to LOAD; out_valid SHALL be 0 on the next cycle.
REQ-030 out_valid SHALL rise on the cycle after inv_done is sampled; start SHALL rise on the cycle after element 15 is accepted.
REQ-031 err SHALL clear when the next start pulse is issued.
REQ-032 Element counters SHALL be 4 bits wide and wrap only via the state transitions above; no partial matrix is ever issued.
REQ-033 in_ready and out_valid SHALL never be 1 in the same cycle.

Reset
REQ-034 While rst=1 at a clock edge, the next state SHALL be LOAD, with counters=0, mat=0, output buffer=0, start=0, out_valid=0, out_data=0, err=0, busy=0.
REQ-035 in_ready SHALL be 0 during reset cycles and 1 on the first cycle after rst deasserts.
REQ-036 Reset asserted mid-LOAD, WAIT or UNLOAD SHALL discard all partial data; the next matrix starts at element 0.

Verification
REQ-037 Stream 3FF0000000000000, 0, 0, 0, 4008000000000000, ... with in_valid held high -> after 16 cycles mat[1023:960]=3FF0000000000000 and mat[63:0]=3FF0000000000000; exactly one start pulse on the next cycle.
REQ-038 Drive in_valid on alternate cycles only -> same mat contents; start is delayed until the 16th acceptance and occurs exactly once.
REQ-039 Model matinv returning inv with element 0 = 4000000000000000, 20 cycles after start -> out_valid rises next cycle and first out_data=4000000000000000; 16 words then busy=0.
REQ-040 Toggle out_ready 1,0,0,1 during UNLOAD -> out_data holds during stalls; no word is lost or duplicated (16 total).
REQ-041 Never assert inv_done, TIMEOUT=64 -> err=1 at cycle 64 of WAIT, FSM in LOAD; the next matrix load clears err at start.
REQ-042 Assert rst after 7 accepted elements -> mat=0; the next 16 elements form a complete matrix with element 0 at mat[1023:960].
